// File: rtl/grant_dispatcher_pkg.sv
// Shared types and defaults for the grant dispatcher.
// The optional assertion set in the top is enabled by GRANT_DISPATCHER_CHECK_EN.
package grant_dispatcher_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} gd_state_e;

    localparam int unsigned GD_N_DEF        = 4;
    localparam int unsigned GD_HOLD_MAX_DEF = 15;

    // Reference decode for up to 16 clients; out-of-range indices give zero.
    function automatic logic [15:0] onehot_of(input int unsigned idx);
        logic [15:0] r_v;
        r_v = '0;
        if (idx < 16) r_v[idx[3:0]] = 1'b1;
        return r_v;
    endfunction

endpackage

// File: rtl/grant_dispatcher_if.sv
// Request/grant bundle between the selection stage (master) and the dispatcher (slave).
interface grant_dispatcher_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
);
    logic            req_valid;
    logic            req_ready;
    logic [IDXW-1:0] req_idx;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic            busy;
    logic            err_idx;
    logic            err_timeout;

    modport slave (
        input  req_valid, req_idx, done,
        output req_ready, gnt, busy, err_idx, err_timeout
    );

    modport master (
        output req_valid, req_idx, done,
        input  req_ready, gnt, busy, err_idx, err_timeout
    );
endinterface

// File: rtl/grant_dispatcher_onehot_decoder.sv
// Combinational index-to-one-hot decoder; out-of-range indices decode to zero.
module grant_dispatcher_onehot_decoder #(
    parameter int unsigned N    = 4,
    parameter int unsigned IDXW = 2
) (
    input  logic [IDXW-1:0] i_idx,
    output logic [N-1:0]    o_onehot,
    output logic            o_in_range
);

    always_comb begin
        o_onehot   = '0;
        o_in_range = (32'(i_idx) < N);
        if (o_in_range) o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/grant_dispatcher.sv
// Decodes an accepted client index into a held one-hot grant with done/timeout release.
// Define GRANT_DISPATCHER_CHECK_EN to compile in simulation-only protocol assertions.
module grant_dispatcher
    import grant_dispatcher_pkg::*;
#(
    parameter int unsigned N        = GD_N_DEF,
    parameter int unsigned HOLD_MAX = GD_HOLD_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    grant_dispatcher_if.slave bus
);

    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNTW = $clog2(HOLD_MAX + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(HOLD_MAX - 1);

    gd_state_e       r_state, w_state_next;
    logic [N-1:0]    r_gnt, w_gnt_next, w_onehot;
    logic [CNTW-1:0] r_cnt, w_cnt_next;
    logic            r_busy, w_busy_next;
    logic            r_err_idx, w_err_idx_next;
    logic            r_err_timeout, w_err_timeout_next;
    logic            w_in_range, w_handshake, w_done_hit, w_timeout;

    grant_dispatcher_onehot_decoder #(
        .N    (N),
        .IDXW (IDXW)
    ) u_decoder (
        .i_idx      (bus.req_idx),
        .o_onehot   (w_onehot),
        .o_in_range (w_in_range)
    );

    assign w_handshake = bus.req_valid && (r_state == IDLE);
    // Only the line currently granted can release; others are masked off.
    assign w_done_hit  = |(bus.done & r_gnt);
    assign w_timeout   = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_gnt         <= '0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_err_idx     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_gnt         <= w_gnt_next;
            r_cnt         <= w_cnt_next;
            r_busy        <= w_busy_next;
            r_err_idx     <= w_err_idx_next;
            r_err_timeout <= w_err_timeout_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_handshake && w_in_range) w_state_next = GRANT;
            GRANT:   if (w_done_hit || w_timeout) w_state_next = RELEASE;
            RELEASE: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_gnt_next         = '0;
        w_cnt_next         = r_cnt;
        w_busy_next        = (w_state_next != IDLE);
        w_err_idx_next     = 1'b0;
        w_err_timeout_next = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (w_handshake) begin
                    if (w_in_range) w_gnt_next = w_onehot;
                    else            w_err_idx_next = 1'b1;
                end
            end
            GRANT: begin
                // done wins over a coincident timeout.
                if (!w_done_hit) begin
                    if (w_timeout) begin
                        w_err_timeout_next = 1'b1;
                    end else begin
                        w_gnt_next = r_gnt;
                        w_cnt_next = r_cnt + CNTW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.gnt         = r_gnt;
    assign bus.busy        = r_busy;
    assign bus.err_idx     = r_err_idx;
    assign bus.err_timeout = r_err_timeout;

`ifdef GRANT_DISPATCHER_CHECK_EN
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(r_gnt));

    a_gnt_in_grant: assert property (@(posedge clk) disable iff (rst)
        (r_gnt != '0) |-> (r_state == GRANT));

    a_foreign_done: assert property (@(posedge clk) disable iff (rst)
        !(r_busy && |(bus.done & ~r_gnt)))
        else $warning("done asserted on a non-granted line");

    a_valid_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.req_valid && !bus.req_ready) |=> bus.req_valid)
        else $error("req_valid dropped before handshake");
`endif

endmodule
